// File: rtl/boot_monitor.sv
// UART-side boot monitor: loads program bytes into RAM, releases the cpu at a
// start address, waits for it to halt, and dumps RAM back to the host.
module boot_monitor #(
   parameter int addr_width = 9
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic [7:0]            tx_data,
   output logic                  tx_start,
   input  logic                  tx_busy,
   output logic [addr_width-1:0] mem_raddr,
   input  logic [7:0]            mem_data_out,
   output logic [addr_width-1:0] mem_waddr,
   output logic [7:0]            mem_data_in,
   output logic                  mem_write,
   output logic                  cpu_reset,
   output logic [addr_width-1:0] cpu_start_address,
   input  logic                  cpu_halted
);

   localparam logic [3:0] IDLE     = 4'd0;
   localparam logic [3:0] ARGS     = 4'd1;
   localparam logic [3:0] LOADDATA = 4'd2;
   localparam logic [3:0] LOADWR   = 4'd3;
   localparam logic [3:0] DUMPADDR = 4'd4;
   localparam logic [3:0] DUMPW1   = 4'd5;
   localparam logic [3:0] DUMPW2   = 4'd6;
   localparam logic [3:0] DUMPSEND = 4'd7;
   localparam logic [3:0] RELEASE  = 4'd8;
   localparam logic [3:0] RUN      = 4'd9;
   localparam logic [3:0] REPLY    = 4'd10;
   localparam logic [3:0] TXHOLD   = 4'd11;
   localparam logic [3:0] TXWAIT   = 4'd12;

   localparam logic [7:0] OP_L  = 8'h4C;
   localparam logic [7:0] OP_D  = 8'h44;
   localparam logic [7:0] OP_R  = 8'h52;
   localparam logic [7:0] RSP_A = 8'h41;
   localparam logic [7:0] RSP_E = 8'h45;
   localparam logic [7:0] RSP_H = 8'h48;

   logic [3:0]            state_q, state_d;
   logic [7:0]            op_q, op_d;
   logic [1:0]            argcnt_q, argcnt_d;
   logic [15:0]           addr_q, addr_d;
   logic [15:0]           len_q, len_d;
   logic [7:0]            byte_q, byte_d;
   logic                  dump_q, dump_d;
   logic [7:0]            tx_data_q, tx_data_d;
   logic                  tx_start_q, tx_start_d;
   logic [addr_width-1:0] raddr_q, raddr_d;
   logic [addr_width-1:0] waddr_q, waddr_d;
   logic [7:0]            wdata_q, wdata_d;
   logic                  we_q, we_d;
   logic                  cpu_rst_q, cpu_rst_d;
   logic [addr_width-1:0] cpu_sa_q, cpu_sa_d;
   logic [15:0]           arg_word;

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      argcnt_d   = argcnt_q;
      addr_d     = addr_q;
      len_d      = len_q;
      byte_d     = byte_q;
      dump_d     = dump_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      raddr_d    = raddr_q;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      we_d       = 1'b0;
      cpu_rst_d  = cpu_rst_q;
      cpu_sa_d   = cpu_sa_q;
      arg_word   = 16'd0;

      case (state_q)
         IDLE: if (rx_valid) begin
            op_d     = rx_data;
            argcnt_d = 2'd0;
            if (rx_data == OP_L || rx_data == OP_D || rx_data == OP_R) begin
               state_d = ARGS;
            end else begin
               byte_d  = RSP_E;
               state_d = REPLY;
            end
         end
         // Arguments arrive big-endian: shift each new byte in at the bottom.
         ARGS: if (rx_valid) begin
            argcnt_d = argcnt_q + 2'd1;
            if (argcnt_q < 2'd2) begin
               arg_word = {addr_q[7:0], rx_data};
               addr_d   = arg_word;
            end else begin
               arg_word = {len_q[7:0], rx_data};
               len_d    = arg_word;
            end
            if (op_q == OP_R && argcnt_q == 2'd1) begin
               cpu_sa_d = arg_word[addr_width-1:0];
               state_d  = RELEASE;
            end else if (argcnt_q == 2'd3) begin
               if (arg_word == 16'd0) begin
                  byte_d  = RSP_A;
                  state_d = REPLY;
               end else if (op_q == OP_L) begin
                  state_d = LOADDATA;
               end else begin
                  dump_d  = 1'b1;
                  state_d = DUMPADDR;
               end
            end
         end
         LOADDATA: if (rx_valid) begin
            waddr_d = addr_q[addr_width-1:0];
            wdata_d = rx_data;
            we_d    = 1'b1;
            addr_d  = addr_q + 16'd1;
            len_d   = len_q - 16'd1;
            state_d = LOADWR;
         end
         LOADWR: begin
            if (len_q == 16'd0) begin
               byte_d  = RSP_A;
               state_d = REPLY;
            end else begin
               state_d = LOADDATA;
            end
         end
         DUMPADDR: begin
            raddr_d = addr_q[addr_width-1:0];
            state_d = DUMPW1;
         end
         DUMPW1: state_d = DUMPW2;
         DUMPW2: state_d = DUMPSEND;
         DUMPSEND: if (!tx_busy) begin
            tx_data_d  = mem_data_out;
            tx_start_d = 1'b1;
            addr_d     = addr_q + 16'd1;
            len_d      = len_q - 16'd1;
            state_d    = TXHOLD;
         end
         // Start address was registered last cycle, so it is stable at release.
         RELEASE: begin
            cpu_rst_d = 1'b0;
            state_d   = RUN;
         end
         RUN: if (cpu_halted) begin
            cpu_rst_d = 1'b1;
            byte_d    = RSP_H;
            state_d   = REPLY;
         end
         REPLY: if (!tx_busy) begin
            tx_data_d  = byte_q;
            tx_start_d = 1'b1;
            state_d    = TXHOLD;
         end
         TXHOLD: state_d = TXWAIT;
         TXWAIT: if (!tx_busy) begin
            if (!dump_q) begin
               state_d = IDLE;
            end else if (len_q == 16'd0) begin
               dump_d  = 1'b0;
               byte_d  = RSP_A;
               state_d = REPLY;
            end else begin
               state_d = DUMPADDR;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         op_q       <= 8'd0;
         argcnt_q   <= 2'd0;
         addr_q     <= 16'd0;
         len_q      <= 16'd0;
         byte_q     <= 8'd0;
         dump_q     <= 1'b0;
         tx_data_q  <= 8'd0;
         tx_start_q <= 1'b0;
         raddr_q    <= '0;
         waddr_q    <= '0;
         wdata_q    <= 8'd0;
         we_q       <= 1'b0;
         cpu_rst_q  <= 1'b1;
         cpu_sa_q   <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         argcnt_q   <= argcnt_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         byte_q     <= byte_d;
         dump_q     <= dump_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         raddr_q    <= raddr_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         cpu_rst_q  <= cpu_rst_d;
         cpu_sa_q   <= cpu_sa_d;
      end
   end

   assign tx_data           = tx_data_q;
   assign tx_start          = tx_start_q;
   assign mem_raddr         = raddr_q;
   assign mem_waddr         = waddr_q;
   assign mem_data_in       = wdata_q;
   assign mem_write         = we_q;
   assign cpu_reset         = cpu_rst_q;
   assign cpu_start_address = cpu_sa_q;

endmodule

// File: tb/tb_boot_monitor.sv
// Bench for boot_monitor: host command driver, UART/RAM/cpu models, and a
// RAM image reference model that predicts every write and transmitted byte.
module tb_boot_monitor;

   localparam int AW  = 9;
   localparam int MSZ = 1 << AW;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic [7:0]    tx_data;
   logic          tx_start;
   logic          tx_busy = 1'b0;
   logic [AW-1:0] mem_raddr;
   logic [7:0]    mem_data_out;
   logic [AW-1:0] mem_waddr;
   logic [7:0]    mem_data_in;
   logic          mem_write;
   logic          cpu_reset;
   logic [AW-1:0] cpu_start_address;
   logic          cpu_halted;

   always #5 clk = ~clk;

   boot_monitor #(.addr_width(AW)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
      .mem_raddr(mem_raddr), .mem_data_out(mem_data_out),
      .mem_waddr(mem_waddr), .mem_data_in(mem_data_in), .mem_write(mem_write),
      .cpu_reset(cpu_reset), .cpu_start_address(cpu_start_address),
      .cpu_halted(cpu_halted)
   );

   // RAM with a two-cycle read latency, plus the expected image of it
   logic [7:0] ram     [MSZ];
   logic [7:0] ref_mem [MSZ];
   logic [7:0] rd_p1;
   always @(posedge clk) begin
      if (mem_write) ram[mem_waddr] <= mem_data_in;
      rd_p1        <= ram[mem_raddr];
      mem_data_out <= rd_p1;
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // UART transmitter (busy 20 cycles per byte), write recorder, reset-edge tracker
   logic [7:0]    got_tx [$];
   int            wr_a [$];
   int            wr_d [$];
   int            busy_cnt = 0;
   logic          prev_txs = 1'b0;
   logic          prev_we  = 1'b0;
   logic          prev_rst = 1'b1;
   logic [AW-1:0] prev_sa  = '0;
   int            fall_cnt = 0;
   logic [AW-1:0] sa_at_fall = '0;

   always @(negedge clk) begin
      if (tx_start) begin
         chk("tx_idle", int'(tx_busy), 0);
         chk("tx_pulse", int'(prev_txs), 0);
         got_tx.push_back(tx_data);
         busy_cnt = 20;
         tx_busy  = 1'b1;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) tx_busy = 1'b0;
      end
      if (mem_write) begin
         chk("wr_rst", int'(cpu_reset), 1);
         chk("wr_pulse", int'(prev_we), 0);
         wr_a.push_back(int'(mem_waddr));
         wr_d.push_back(int'(mem_data_in));
      end
      if (prev_rst && !cpu_reset) begin
         fall_cnt++;
         sa_at_fall = prev_sa;
      end
      prev_txs = tx_start;
      prev_we  = mem_write;
      prev_rst = cpu_reset;
      prev_sa  = cpu_start_address;
   end

   logic [7:0] ld_data [$];

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat ($urandom_range(1, 4)) @(negedge clk);
   endtask

   task automatic send16(input logic [15:0] w);
      send(w[15:8]);
      send(w[7:0]);
   endtask

   task automatic clear_obs();
      got_tx.delete();
      wr_a.delete();
      wr_d.delete();
   endtask

   task automatic wait_tx(input int n, input string tag);
      int cyc = 0;
      while (got_tx.size() < n && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      chk(tag, got_tx.size(), n);
   endtask

   task automatic settle();
      int cyc = 0;
      while (tx_busy && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic do_load(input logic [15:0] a, input int n);
      logic [15:0] n16 = 16'(n);
      clear_obs();
      send(8'h4C);
      send16(a);
      send16(n16);
      for (int k = 0; k < n; k++) begin
         send(ld_data[k]);
         ref_mem[(int'(a) + k) % MSZ] = ld_data[k];
      end
      wait_tx(1, "ld_reply");
      if (got_tx.size() > 0) chk("ld_ack", int'(got_tx[0]), 'h41);
      chk("ld_wrcnt", wr_a.size(), n);
      for (int k = 0; k < n && k < wr_a.size(); k++) begin
         chk("ld_waddr", wr_a[k], (int'(a) + k) % MSZ);
         chk("ld_wdata", wr_d[k], int'(ld_data[k]));
      end
      chk("ld_cpurst", int'(cpu_reset), 1);
      settle();
      chk("ld_total", got_tx.size(), 1);
   endtask

   task automatic do_dump(input logic [15:0] a, input int n);
      logic [15:0] n16 = 16'(n);
      clear_obs();
      send(8'h44);
      send16(a);
      send16(n16);
      wait_tx(n + 1, "dp_cnt");
      for (int k = 0; k < n && k < got_tx.size(); k++)
         chk("dp_data", int'(got_tx[k]), int'(ref_mem[(int'(a) + k) % MSZ]));
      if (got_tx.size() > n) chk("dp_ack", int'(got_tx[n]), 'h41);
      chk("dp_nowr", wr_a.size(), 0);
      settle();
      chk("dp_total", got_tx.size(), n + 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cyc;
      reset      = 1'b1;
      rx_data    = 8'd0;
      rx_valid   = 1'b0;
      cpu_halted = 1'b0;
      for (int i = 0; i < MSZ; i++) begin
         ram[i]     = 8'($urandom);
         ref_mem[i] = ram[i];
      end
      repeat (3) @(negedge clk);
      chk("rst_cpu_reset", int'(cpu_reset), 1);
      chk("rst_cpu_sa", int'(cpu_start_address), 0);
      chk("rst_tx_start", int'(tx_start), 0);
      chk("rst_tx_data", int'(tx_data), 0);
      chk("rst_mem_write", int'(mem_write), 0);
      chk("rst_raddr", int'(mem_raddr), 0);
      chk("rst_waddr", int'(mem_waddr), 0);
      chk("rst_wdata", int'(mem_data_in), 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      ld_data = '{8'hAA, 8'hBB, 8'hCC};
      do_load(16'h0010, 3);
      do_dump(16'h0010, 3);
      ld_data = '{8'h11, 8'h22};
      do_load(16'h01FF, 2);
      do_dump(16'h01FF, 2);
      ld_data.delete();
      do_load(16'h0123, 0);
      do_dump(16'h0055, 0);

      // Release the cpu, feed junk while it runs, then halt it
      clear_obs();
      fall_cnt = 0;
      send(8'h52);
      send16(16'h0020);
      cyc = 0;
      while (cpu_reset && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("run_fall", int'(cpu_reset), 0);
      chk("run_falls", fall_cnt, 1);
      chk("run_sa_early", int'(sa_at_fall), 'h20);
      chk("run_sa", int'(cpu_start_address), 'h20);
      send(8'h4C);
      send(8'h7A);
      send(8'h44);
      repeat (50) @(negedge clk);
      chk("run_held", int'(cpu_reset), 0);
      chk("run_notx", got_tx.size(), 0);
      chk("run_nowr", wr_a.size(), 0);
      cpu_halted = 1'b1;
      @(negedge clk);
      chk("halt_rst", int'(cpu_reset), 1);
      cpu_halted = 1'b0;
      wait_tx(1, "halt_reply");
      if (got_tx.size() > 0) chk("halt_h", int'(got_tx[0]), 'h48);
      settle();
      chk("halt_total", got_tx.size(), 1);

      clear_obs();
      send(8'h7A);
      wait_tx(1, "err_reply");
      if (got_tx.size() > 0) chk("err_e", int'(got_tx[0]), 'h45);
      settle();
      chk("err_total", got_tx.size(), 1);
      do_dump(16'h0010, 1);

      for (int i = 0; i < 6; i++) begin
         logic [15:0] a;
         int n;
         a = 16'($urandom);
         n = $urandom_range(0, 6);
         ld_data.delete();
         for (int k = 0; k < n; k++) ld_data.push_back(8'($urandom));
         do_load(a, n);
         do_dump(a, n);
         do_dump(16'($urandom), $urandom_range(0, 4));
      end

      // Reset in the middle of a load, after two data bytes
      clear_obs();
      send(8'h4C);
      send16(16'h0040);
      send16(16'h0005);
      for (int k = 0; k < 2; k++) begin
         logic [7:0] b;
         b = 8'($urandom);
         send(b);
         ref_mem[8'h40 + k] = b;
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_cpu_reset", int'(cpu_reset), 1);
      chk("mid_mem_write", int'(mem_write), 0);
      chk("mid_tx_start", int'(tx_start), 0);
      chk("mid_waddr", int'(mem_waddr), 0);
      reset = 1'b0;
      chk("mid_wrcnt", wr_a.size(), 2);
      settle();
      chk("mid_notx", got_tx.size(), 0);
      do_dump(16'h0040, 3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/boot_monitor.md
Name: boot_monitor

Overview:
- UART-side monitor that sits directly upstream of the cpu and its byte-wide program RAM.
- Accepts host commands as received bytes and loads program bytes into RAM, then releases the cpu at a given start address.
- Waits for the cpu to halt, then lets the host dump RAM, including the register dump the cpu writes from address 2.
- Owns the RAM port whenever it holds the cpu in reset; the top level muxes the RAM port on cpu_reset.

Parameters:
addr_width, 9, RAM address width; must match the cpu's addr_width.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_data  in  8  received byte from UART receiver
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  byte to UART transmitter
tx_start  out  1  one-cycle strobe requesting transmission of tx_data
tx_busy  in  1  transmitter busy; goes high at most 1 cycle after tx_start
mem_raddr  out  addr_width  RAM read address
mem_data_out  in  8  RAM read data, valid 2 cycles after mem_raddr changes
mem_waddr  out  addr_width  RAM write address
mem_data_in  out  8  RAM write data
mem_write  out  1  RAM write enable, one-cycle pulse
cpu_reset  out  1  cpu reset; high = monitor owns RAM
cpu_start_address  out  addr_width  start address presented to cpu
cpu_halted  in  1  cpu halted flag

Behaviour:
- One clock, clk. reset is synchronous and active-high; reset has priority over everything, including a command mid-operation.
- Reset values:
  - state IDLE, cpu_reset=1, cpu_start_address=0, tx_start=0, tx_data=0, mem_write=0, mem_raddr=0, mem_waddr=0, mem_data_in=0.
  - Counters and argument registers are 0.
- Command format: ASCII opcode byte, then big-endian 16-bit arguments.
  - Addresses are truncated to addr_width bits.
  - Address increments wrap modulo 2^addr_width.
  - Length is a 16-bit count.
- 'L'(0x4C) A_hi A_lo N_hi N_lo, then N data bytes:
  - Data byte k is written to A+k.
  - Each write: mem_waddr/mem_data_in are set and mem_write=1 in the cycle after the rx_valid that delivered the byte.
  - After the last byte (or immediately after N_lo if N=0), reply 'A'(0x41).
- 'D'(0x44) A_hi A_lo N_hi N_lo:
  - For k=0..N-1: set mem_raddr=A+k, wait 2 cycles, latch mem_data_out, transmit it.
  - Then reply 'A'. N=0 replies 'A' only.
- 'R'(0x52) A_hi A_lo:
  - cpu_start_address<=A.
  - The following cycle, cpu_reset<=0 (start address is stable ≥1 cycle before release).
  - State RUN: wait for cpu_halted=1. The cycle after it is sampled high, cpu_reset<=1 and reply 'H'(0x48).
  - There is no timeout; only reset leaves RUN.
- Any other opcode byte in IDLE: reply 'E'(0x45), return to IDLE.
- rx_valid strobes are ignored in every state that is not collecting bytes (REPLY, TX wait, dump, RUN). Bytes arriving there are dropped, not queued.
- States: IDLE, ARGS (collect 2 or 4 arg bytes, byte counter 0..3), LOADDATA, LOADWR, DUMPADDR, DUMPW1, DUMPW2, DUMPSEND, RELEASE, RUN, REPLY, TXHOLD, TXWAIT.
  - Transitions: IDLE->ARGS on 'L'/'D'/'R' and ->REPLY otherwise.
  - ARGS->LOADDATA / DUMPADDR / RELEASE after the last arg byte.
  - LOADDATA<->LOADWR per byte.
  - DUMPADDR->DUMPW1->DUMPW2->DUMPSEND->TXHOLD->TXWAIT->DUMPADDR (or REPLY when the count is exhausted).
  - RELEASE->RUN->REPLY.
  - REPLY->TXHOLD->TXWAIT->IDLE.
- Transmit handshake:
  - tx_start is pulsed for exactly one cycle, only when tx_busy=0.
  - TXHOLD ignores tx_busy for one cycle.
  - TXWAIT proceeds on the first cycle with tx_busy=0.
- mem_write is never asserted while cpu_reset=0. RAM outputs are don't-care while the cpu runs.
- Remaining-byte counter is 16 bits; it decrements once per byte, and completion is when it reaches 0 (no underflow).

Test Plan:
- Reset, then send 'L',0x00,0x10,0x00,0x03,0xAA,0xBB,0xCC -> writes 0xAA@0x10, 0xBB@0x11, 0xCC@0x12 with one-cycle mem_write pulses; then tx 'A'; cpu_reset stays 1.
- 'D',0x00,0x10,0x00,0x03 after the above -> tx 0xAA,0xBB,0xCC,'A'; each tx_start only while tx_busy=0 (model busy for 20 cycles per byte).
- 'L',0x01,0xFF,0x00,0x02,0x11,0x22 with addr_width=9 -> writes 0x11@0x1FF, 0x22@0x000 (wrap); N=0 variant -> immediate 'A', no mem_write.
- 'R',0x00,0x20 -> cpu_start_address=0x020 one cycle before cpu_reset falls; assert cpu_halted 50 cycles later -> cpu_reset=1 next cycle, tx 'H'; extra rx bytes sent during RUN are ignored.
- Send 0x7A -> tx 'E', back to IDLE. Assert reset mid-'L' after 2 data bytes -> cpu_reset=1, mem_write=0, IDLE; a fresh 'D' works normally.
